dram_port_arbiter: RTL
======================

# dram_port_arbiter

Round-robin arbiter that shares one DDR2 address/write-data FIFO port between NUM_REQ graphics requesters (frame filler, line engine, command processor fetch). It sits between those engines and the request controller's single graphics port. It keeps every DDR2 transaction atomic: one address entry plus two 128-bit data beats for a write, or one address entry for a read. Non-granted requesters see their FIFOs as full.

## Interface
- NUM_REQ, 2: number of requesters, 2..4.
- clk  in  1  cpu clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_af_wr_en  in  NUM_REQ  per-requester address-FIFO write strobe; also acts as the request.
- req_af_cmd_din  in  3*NUM_REQ  per-requester command (000 write, 001 read).
- req_af_addr_din  in  31*NUM_REQ  per-requester DDR2 address.
- req_wdf_wr_en  in  NUM_REQ  per-requester write-data strobe.
- req_wdf_din  in  128*NUM_REQ  per-requester write data.
- req_wdf_mask_din  in  16*NUM_REQ  per-requester byte mask.
- req_af_full, req_wdf_full  out  NUM_REQ each  per-requester back-pressure.
- grant  out  NUM_REQ  one-hot current owner; 0 when none.
- af_full, wdf_full  in  1 each  downstream FIFO full.
- af_wr_en, wdf_wr_en  out  1 each  downstream strobes.
- af_cmd_din  out  3 ; af_addr_din  out  31 ; wdf_din  out  128 ; wdf_mask_din  out  16  muxed downstream payload.
- grant_count  out  16*NUM_REQ  only with DRAM_ARB_STATS_EN; otherwise tied to 0.

## Operation
- States: ARB and OWN.
- ARB: the pending set is req_af_wr_en | req_wdf_wr_en.
  - Pick the first pending index at or after rr_ptr, wrapping.
  - Register it into grant and enter OWN.
  - Stay in ARB if nothing is pending.
- OWN: for the granted index g:
  - af_wr_en = req_af_wr_en[g] & ~af_full. wdf_wr_en follows the same rule with wdf_full.
  - Payloads are muxed from g.
  - req_af_full[g] = af_full and req_wdf_full[g] = wdf_full. All other req_*_full bits read 1.
- Beat accounting in OWN:
  - af_seen sets on an accepted address beat. cmd_q latches the accepted command.
  - wdf_cnt (2 bits) increments on each accepted data beat.
  - Data beats may precede, coincide with, or follow the address beat.
- Completion:
  - Read: af_seen with cmd_q=001.
  - Write: af_seen and wdf_cnt=2.
  - Completion is evaluated including the beat accepted in the current cycle.
  - On completion: rr_ptr ← g+1 mod NUM_REQ, grant ← 0, counters cleared, return to ARB.
- Once wdf_cnt reaches 2, further data beats from g are blocked: req_wdf_full[g]=1 and wdf_wr_en=0.
- After af_seen, further address beats are blocked the same way.
- Simultaneous requests resolve by rr_ptr only. A requester that holds its strobe through its own grant is not re-granted until every other pending requester has been served.
- A command other than 000 or 001 is treated as a read.

## Timing
- Reset values:
  - grant=0, state=ARB, rr_ptr=0, counters 0.
  - af_wr_en=wdf_wr_en=0, all req_*_full=1.
  - Payload outputs=0, grant_count=0.
- Arbitration latency: 1 cycle from the first pending strobe to grant.
- The first downstream write can occur in the cycle grant is visible.
- One ARB bubble cycle between consecutive transactions.
- Minimum write transaction: ARB + 2 OWN cycles (addr+data0, then data1).
- Downstream strobes and the granted requester's full flags are combinational from the inputs within the cycle; grant is registered.
- Downstream full stalls the owner indefinitely; the grant is never revoked mid-transaction.
- Reset asserted mid-transaction: immediate return to reset values. A partial transaction already in the FIFOs is the requesters' problem, since the FIFOs share the same reset.

## Configuration
- DRAM_ARB_STATS_EN defined:
  - One 16-bit saturating counter per requester, incremented on each completed transaction.
  - Saturates at 16'hFFFF and is cleared by rst.
  - Exposed on grant_count.
- Undefined: counters are not built and grant_count is constant 0.

## Structure
- Package dram_arb_pkg holds:
  - CMD_WRITE=3'b000 and CMD_READ=3'b001.
  - AF_ADDR_W=31, WDF_DATA_W=128, WDF_MASK_W=16.
  - WRITE_BEATS=2.
  - The state enum {ARB, OWN}.
- Sub-module rr_priority_picker(NUM_REQ): combinational; takes pending and rr_ptr, returns a one-hot pick and a valid flag.

## Test plan
- Single write: requester 0 drives addr 0x0000100, cmd 000, two data beats over 3 cycles, no full.
  - Expect grant=01 one cycle later, downstream af_wr_en×1 and wdf_wr_en×2 with identical payloads.
  - Expect grant→0 after the second beat.
- Contention: both requesters strobe from cycle 0.
  - Expect grant order 01, 10, 01, 10.
  - Expect no interleaving of requester 1 beats inside a requester 0 transaction.
- Back-pressure: wdf_full=1 for 5 cycles after the first data beat.
  - Expect grant held, req_wdf_full[0]=1, no downstream wdf_wr_en.
  - Expect completion 1 cycle after wdf_full drops.
- Data-before-address plus read: requester 1 sends 2 data beats, then the address; requester 0 sends a read to 0x0000200.
  - Expect write completion only after the address beat, and the read to complete after a single af beat.
- Async reset asserted mid-OWN after 1 data beat.
  - Expect grant=0, all req_*_full=1, af_wr_en=0 in the same cycle.
  - Expect the next grant to go to requester 0.
- With DRAM_ARB_STATS_EN: 70000 requester-0 reads.
  - Expect grant_count[0]=16'hFFFF and grant_count[1]=0.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared constants, state encoding and beat structs for the DDR2 graphics port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dram_arb_pkg;

    localparam logic [2:0] CMD_WRITE   = 3'b000;
    localparam logic [2:0] CMD_READ    = 3'b001;

    localparam int CMD_W       = 3;
    localparam int AF_ADDR_W   = 31;
    localparam int WDF_DATA_W  = 128;
    localparam int WDF_MASK_W  = 16;
    localparam int WRITE_BEATS = 2;
    localparam int STAT_W      = 16;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_t;

    // One address-FIFO entry.
    typedef struct packed {
        logic [CMD_W-1:0]     cmd;
        logic [AF_ADDR_W-1:0] addr;
    } af_beat_t;

    // One write-data-FIFO entry.
    typedef struct packed {
        logic [WDF_DATA_W-1:0] data;
        logic [WDF_MASK_W-1:0] mask;
    } wdf_beat_t;

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Bundle of requester-side FIFO ports and the single downstream graphics port.
// Latency: n/a (wiring only).
// Backpressure: req_*_full toward requesters, af_full/wdf_full from downstream.
interface dram_port_arbiter_if #(parameter int NUM_REQ = 2);
    import dram_arb_pkg::*;

    // requester side
    logic [NUM_REQ-1:0]            req_af_wr_en;
    logic [CMD_W*NUM_REQ-1:0]      req_af_cmd_din;
    logic [AF_ADDR_W*NUM_REQ-1:0]  req_af_addr_din;
    logic [NUM_REQ-1:0]            req_wdf_wr_en;
    logic [WDF_DATA_W*NUM_REQ-1:0] req_wdf_din;
    logic [WDF_MASK_W*NUM_REQ-1:0] req_wdf_mask_din;
    logic [NUM_REQ-1:0]            req_af_full;
    logic [NUM_REQ-1:0]            req_wdf_full;
    logic [NUM_REQ-1:0]            grant;
    logic [STAT_W*NUM_REQ-1:0]     grant_count;

    // downstream side
    logic                          af_full;
    logic                          wdf_full;
    logic                          af_wr_en;
    logic                          wdf_wr_en;
    logic [CMD_W-1:0]              af_cmd_din;
    logic [AF_ADDR_W-1:0]          af_addr_din;
    logic [WDF_DATA_W-1:0]         wdf_din;
    logic [WDF_MASK_W-1:0]         wdf_mask_din;

    // arbiter view
    modport slave (
        input  req_af_wr_en, req_af_cmd_din, req_af_addr_din,
        input  req_wdf_wr_en, req_wdf_din, req_wdf_mask_din,
        input  af_full, wdf_full,
        output req_af_full, req_wdf_full, grant, grant_count,
        output af_wr_en, wdf_wr_en, af_cmd_din, af_addr_din, wdf_din, wdf_mask_din
    );

    // environment view (requesters + downstream FIFOs)
    modport master (
        output req_af_wr_en, req_af_cmd_din, req_af_addr_din,
        output req_wdf_wr_en, req_wdf_din, req_wdf_mask_din,
        output af_full, wdf_full,
        input  req_af_full, req_wdf_full, grant, grant_count,
        input  af_wr_en, wdf_wr_en, af_cmd_din, af_addr_din, wdf_din, wdf_mask_din
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Picks the first pending requester at or after rr_ptr, wrapping around.
// Latency: combinational.
// Backpressure: none; pick_vld low when nothing is pending.
module rr_priority_picker #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         pending,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         pick,
    output logic                       pick_vld
);

    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [NUM_REQ-1:0] at_or_after;

    // Prefer the lowest pending bit at/after the pointer; otherwise wrap to the lowest overall.
    always_comb begin
        at_or_after = pending & ~((ONE << rr_ptr) - ONE);
        if (|at_or_after) begin
            pick = at_or_after & (~at_or_after + ONE);
        end else begin
            pick = pending & (~pending + ONE);
        end
        pick_vld = |pending;
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin owner of the shared DDR2 af/wdf port; keeps each read (1 af) or write (1 af + 2 wdf) atomic.
// Latency: grant 1 cycle after first pending strobe; downstream strobes/payload combinational while owned.
// Backpressure: non-owners see full; owner sees downstream full; optional DRAM_ARB_STATS_EN adds grant_count.
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                clk,
    input  logic                rst,
    dram_port_arbiter_if.slave  bus
);

    localparam int         PTR_W = $clog2(NUM_REQ);
    localparam logic [1:0] BEATS = 2'(WRITE_BEATS);

    arb_state_t          state, state_n;
    logic [NUM_REQ-1:0]  grant_q, grant_n;
    logic [PTR_W-1:0]    g_idx, g_idx_n;
    logic [PTR_W-1:0]    rr_ptr, rr_ptr_n;
    logic                af_seen, af_seen_n;
    logic [CMD_W-1:0]    cmd_q, cmd_n;
    logic [1:0]          wdf_cnt, wdf_cnt_n;
    logic                done;
    logic                af_blk, wdf_blk;

    logic [NUM_REQ-1:0]  pending;
    logic [NUM_REQ-1:0]  pick;
    logic                pick_vld;
    logic [PTR_W-1:0]    pick_idx;

    af_beat_t            af_arr  [NUM_REQ];
    wdf_beat_t           wdf_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign af_arr[i]  = {bus.req_af_cmd_din[i*CMD_W +: CMD_W],
                             bus.req_af_addr_din[i*AF_ADDR_W +: AF_ADDR_W]};
        assign wdf_arr[i] = {bus.req_wdf_din[i*WDF_DATA_W +: WDF_DATA_W],
                             bus.req_wdf_mask_din[i*WDF_MASK_W +: WDF_MASK_W]};
    end

    assign pending = bus.req_af_wr_en | bus.req_wdf_wr_en;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .pending  (pending),
        .rr_ptr   (rr_ptr),
        .pick     (pick),
        .pick_vld (pick_vld)
    );

    // One-hot pick to index so the owner can be held as a mux select.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    // Arbitration/ownership next-state and the owner's combinational port view.
    always_comb begin
        state_n          = state;
        grant_n          = grant_q;
        g_idx_n          = g_idx;
        rr_ptr_n         = rr_ptr;
        af_seen_n        = af_seen;
        cmd_n            = cmd_q;
        wdf_cnt_n        = wdf_cnt;
        done             = 1'b0;
        af_blk           = 1'b1;
        wdf_blk          = 1'b1;
        bus.af_wr_en     = 1'b0;
        bus.wdf_wr_en    = 1'b0;
        bus.af_cmd_din   = '0;
        bus.af_addr_din  = '0;
        bus.wdf_din      = '0;
        bus.wdf_mask_din = '0;
        bus.req_af_full  = '1;
        bus.req_wdf_full = '1;

        case (state)
            ARB: begin
                if (pick_vld) begin
                    state_n = OWN;
                    grant_n = pick;
                    g_idx_n = pick_idx;
                end
            end
            OWN: begin
                // Owner sees real downstream full, plus a block once its beats are used up.
                af_blk  = bus.af_full | af_seen;
                wdf_blk = bus.wdf_full | (wdf_cnt == BEATS);
                bus.req_af_full[g_idx]  = af_blk;
                bus.req_wdf_full[g_idx] = wdf_blk;
                bus.af_wr_en     = bus.req_af_wr_en[g_idx] & ~af_blk;
                bus.wdf_wr_en    = bus.req_wdf_wr_en[g_idx] & ~wdf_blk;
                bus.af_cmd_din   = af_arr[g_idx].cmd;
                bus.af_addr_din  = af_arr[g_idx].addr;
                bus.wdf_din      = wdf_arr[g_idx].data;
                bus.wdf_mask_din = wdf_arr[g_idx].mask;

                if (bus.af_wr_en) begin
                    af_seen_n = 1'b1;
                    cmd_n     = af_arr[g_idx].cmd;
                end
                if (bus.wdf_wr_en) wdf_cnt_n = wdf_cnt + 2'd1;

                // Anything other than a write command is finished by its address beat alone.
                done = af_seen_n & ((cmd_n != CMD_WRITE) | (wdf_cnt_n == BEATS));
                if (done) begin
                    state_n   = ARB;
                    grant_n   = '0;
                    rr_ptr_n  = (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
                    af_seen_n = 1'b0;
                    cmd_n     = CMD_WRITE;
                    wdf_cnt_n = 2'd0;
                end
            end
            default: state_n = ARB;
        endcase
    end

    // State register; reset drops any partial ownership immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB;
            grant_q <= '0;
            g_idx   <= '0;
            rr_ptr  <= '0;
            af_seen <= 1'b0;
            cmd_q   <= CMD_WRITE;
            wdf_cnt <= 2'd0;
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            g_idx   <= g_idx_n;
            rr_ptr  <= rr_ptr_n;
            af_seen <= af_seen_n;
            cmd_q   <= cmd_n;
            wdf_cnt <= wdf_cnt_n;
        end
    end

    assign bus.grant = grant_q;

`ifdef DRAM_ARB_STATS_EN
    logic [STAT_W-1:0] stat_cnt [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        // Saturating count of completed transactions for requester i.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stat_cnt[i] <= '0;
            end else if (done && (g_idx == PTR_W'(i)) && (stat_cnt[i] != '1)) begin
                stat_cnt[i] <= stat_cnt[i] + 1'b1;
            end
        end
        assign bus.grant_count[i*STAT_W +: STAT_W] = stat_cnt[i];
    end
`else
    assign bus.grant_count = '0;
`endif

endmodule
